// File: rtl/ccc_resp_engine.sv
// I3C target CCC response engine: answers direct GET CCCs with a byte
// stream and applies RSTACT, ENEC/DISEC and ENTHDR0 side effects.
module ccc_resp_engine #(
   parameter int IbiPayloadEn = 1,
   parameter int PidBytes     = 6
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ccc_valid_i,
   input  logic [7:0]  ccc_code_i,
   input  logic        def_valid_i,
   input  logic [7:0]  def_byte_i,
   input  logic        ccc_abort_i,
   input  logic        hdr_exit_i,
   input  logic [15:0] mrl_i,
   input  logic [15:0] mwl_i,
   input  logic [15:0] status_i,
   input  logic [7:0]  ibi_size_i,
   input  logic [7:0]  bcr_i,
   input  logic [7:0]  dcr_i,
   input  logic [47:0] pid_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [7:0]  resp_data_o,
   output logic        resp_last_o,
   output logic [7:0]  rstact_o,
   output logic        rstact_valid_o,
   output logic        int_en_o,
   output logic        crr_en_o,
   output logic        hj_en_o,
   output logic        hdr_mode_o,
   output logic        unsupported_o
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_DEF,
      WAIT_DATA
   } state_e;

   localparam logic [2:0] PidLen   = 3'(PidBytes);
   localparam logic [2:0] MrlLen   = (IbiPayloadEn != 0) ? 3'd3 : 3'd2;
   localparam int         PidShift = 8 * (6 - PidBytes);

   state_e      state_q, state_d;
   logic [47:0] buf_q, buf_d;
   logic [2:0]  len_q, len_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ensel_q, ensel_d;
   logic [7:0]  rstact_q, rstact_d;
   logic        rstv_q, rstv_d;
   logic        int_q, int_d;
   logic        crr_q, crr_d;
   logic        hj_q, hj_d;
   logic        hdr_q, hdr_d;
   logic        unsup_q, unsup_d;
   logic        last_byte;

   assign last_byte = (cnt_q == (len_q - 3'd1));

   // Next-state and command decode; abort overrides every other event.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      ensel_d  = ensel_q;
      rstact_d = rstact_q;
      rstv_d   = 1'b0;
      int_d    = int_q;
      crr_d    = crr_q;
      hj_d     = hj_q;
      hdr_d    = hdr_q;
      unsup_d  = 1'b0;
      if (hdr_exit_i) begin
         hdr_d = 1'b0;
      end
      if (ccc_abort_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ccc_valid_i && !hdr_q) begin
                  cnt_d = '0;
                  case (ccc_code_i)
                     8'h8B: begin
                        state_d = SEND;
                        buf_d   = {mwl_i, 32'h0};
                        len_d   = 3'd2;
                     end
                     8'h8C: begin
                        state_d = SEND;
                        buf_d   = {mrl_i, ibi_size_i, 24'h0};
                        len_d   = MrlLen;
                     end
                     8'h8D: begin
                        state_d = SEND;
                        buf_d   = pid_i << PidShift;
                        len_d   = PidLen;
                     end
                     8'h8E: begin
                        state_d = SEND;
                        buf_d   = {bcr_i, 40'h0};
                        len_d   = 3'd1;
                     end
                     8'h8F: begin
                        state_d = SEND;
                        buf_d   = {dcr_i, 40'h0};
                        len_d   = 3'd1;
                     end
                     8'h90: begin
                        state_d = SEND;
                        buf_d   = {status_i, 32'h0};
                        len_d   = 3'd2;
                     end
                     8'h2A, 8'h9A: state_d = WAIT_DEF;
                     8'h00, 8'h80: begin
                        state_d = WAIT_DATA;
                        ensel_d = 1'b1;
                     end
                     8'h01, 8'h81: begin
                        state_d = WAIT_DATA;
                        ensel_d = 1'b0;
                     end
                     8'h20:   hdr_d   = 1'b1;
                     default: unsup_d = 1'b1;
                  endcase
               end
            end
            SEND: begin
               if (resp_ready_i) begin
                  if (last_byte) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     buf_d = {buf_q[39:0], 8'h00};
                     cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                  end
               end
            end
            WAIT_DEF: begin
               if (def_valid_i) begin
                  state_d = IDLE;
                  if (def_byte_i <= 8'h02) begin
                     rstact_d = def_byte_i;
                     rstv_d   = 1'b1;
                  end
               end
            end
            WAIT_DATA: begin
               if (def_valid_i) begin
                  state_d = IDLE;
                  if (def_byte_i[0]) int_d = ensel_q;
                  if (def_byte_i[1]) crr_d = ensel_q;
                  if (def_byte_i[3]) hj_d  = ensel_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         ensel_q  <= 1'b0;
         rstact_q <= '0;
         rstv_q   <= 1'b0;
         int_q    <= 1'b1;
         crr_q    <= 1'b1;
         hj_q     <= 1'b1;
         hdr_q    <= 1'b0;
         unsup_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         ensel_q  <= ensel_d;
         rstact_q <= rstact_d;
         rstv_q   <= rstv_d;
         int_q    <= int_d;
         crr_q    <= crr_d;
         hj_q     <= hj_d;
         hdr_q    <= hdr_d;
         unsup_q  <= unsup_d;
      end
   end

   assign resp_valid_o   = (state_q == SEND);
   assign resp_data_o    = buf_q[47:40];
   assign resp_last_o    = (state_q == SEND) && last_byte;
   assign rstact_o       = rstact_q;
   assign rstact_valid_o = rstv_q;
   assign int_en_o       = int_q;
   assign crr_en_o       = crr_q;
   assign hj_en_o        = hj_q;
   assign hdr_mode_o     = hdr_q;
   assign unsupported_o  = unsup_q;

endmodule

// File: tb/tb_ccc_resp_engine.sv
// Bench for ccc_resp_engine: two parameterisations driven in lockstep,
// byte streams scoreboarded against a value-level model.
module tb_ccc_resp_engine;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        ccc_valid_i;
   logic [7:0]  ccc_code_i;
   logic        def_valid_i;
   logic [7:0]  def_byte_i;
   logic        ccc_abort_i;
   logic        hdr_exit_i;
   logic [15:0] mrl_i, mwl_i, status_i;
   logic [7:0]  ibi_size_i, bcr_i, dcr_i;
   logic [47:0] pid_i;
   logic        resp_ready_i;

   logic       r0_valid, r0_last, rv0, int0, crr0, hj0, hdr0, uns0;
   logic [7:0] r0_data, rst0;
   logic       r1_valid, r1_last, rv1, int1, crr1, hj1, hdr1, uns1;
   logic [7:0] r1_data, rst1;

   int n_checks = 0;
   int n_err = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   bit rdy_rand = 1'b0;

   bit [7:0] m_rstact;
   bit m_int, m_crr, m_hj, m_hdr;

   always #5 clk = ~clk;

   ccc_resp_engine u0 (
      .clk_i(clk), .rst_ni(rst_ni),
      .ccc_valid_i(ccc_valid_i), .ccc_code_i(ccc_code_i),
      .def_valid_i(def_valid_i), .def_byte_i(def_byte_i),
      .ccc_abort_i(ccc_abort_i), .hdr_exit_i(hdr_exit_i),
      .mrl_i(mrl_i), .mwl_i(mwl_i), .status_i(status_i),
      .ibi_size_i(ibi_size_i), .bcr_i(bcr_i), .dcr_i(dcr_i),
      .pid_i(pid_i),
      .resp_valid_o(r0_valid), .resp_ready_i(resp_ready_i),
      .resp_data_o(r0_data), .resp_last_o(r0_last),
      .rstact_o(rst0), .rstact_valid_o(rv0),
      .int_en_o(int0), .crr_en_o(crr0), .hj_en_o(hj0),
      .hdr_mode_o(hdr0), .unsupported_o(uns0)
   );

   ccc_resp_engine #(.IbiPayloadEn(0), .PidBytes(3)) u1 (
      .clk_i(clk), .rst_ni(rst_ni),
      .ccc_valid_i(ccc_valid_i), .ccc_code_i(ccc_code_i),
      .def_valid_i(def_valid_i), .def_byte_i(def_byte_i),
      .ccc_abort_i(ccc_abort_i), .hdr_exit_i(hdr_exit_i),
      .mrl_i(mrl_i), .mwl_i(mwl_i), .status_i(status_i),
      .ibi_size_i(ibi_size_i), .bcr_i(bcr_i), .dcr_i(dcr_i),
      .pid_i(pid_i),
      .resp_valid_o(r1_valid), .resp_ready_i(resp_ready_i),
      .resp_data_o(r1_data), .resp_last_o(r1_last),
      .rstact_o(rst1), .rstact_valid_o(rv1),
      .int_en_o(int1), .crr_en_o(crr1), .hj_en_o(hj1),
      .hdr_mode_o(hdr1), .unsupported_o(uns1)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response value and length as the command set defines them.
   task automatic model_resp(input logic [7:0] code, input int ibi_en,
                             input int pidb, output logic [63:0] val,
                             output int n);
      val = 64'h0;
      n = 0;
      case (code)
         8'h8B: begin val = 64'(mwl_i); n = 2; end
         8'h8C: begin
            if (ibi_en != 0) begin
               val = 64'(mrl_i) * 256 + 64'(ibi_size_i);
               n = 3;
            end else begin
               val = 64'(mrl_i);
               n = 2;
            end
         end
         8'h8D: begin
            val = 64'(pid_i) % (64'd1 << (8 * pidb));
            n = pidb;
         end
         8'h8E: begin val = 64'(bcr_i); n = 1; end
         8'h8F: begin val = 64'(dcr_i); n = 1; end
         8'h90: begin val = 64'(status_i); n = 2; end
         default: n = 0;
      endcase
   endtask

   task automatic push_expected(input logic [7:0] code);
      logic [63:0] v;
      int n;
      model_resp(code, 1, 6, v, n);
      for (int i = 0; i < n; i++)
         q0.push_back({(i == n - 1), 8'(v >> (8 * (n - 1 - i)))});
      model_resp(code, 0, 3, v, n);
      for (int i = 0; i < n; i++)
         q1.push_back({(i == n - 1), 8'(v >> (8 * (n - 1 - i)))});
   endtask

   function automatic bit is_known(input logic [7:0] c);
      return c inside {8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F, 8'h90,
                       8'h2A, 8'h9A, 8'h00, 8'h80, 8'h01, 8'h81, 8'h20};
   endfunction

   task automatic rand_src();
      mrl_i = 16'($urandom);
      mwl_i = 16'($urandom);
      status_i = 16'($urandom);
      ibi_size_i = 8'($urandom);
      bcr_i = 8'($urandom);
      dcr_i = 8'($urandom);
      pid_i = {16'($urandom), 32'($urandom)};
   endtask

   task automatic issue(input logic [7:0] code);
      ccc_valid_i = 1'b1;
      ccc_code_i = code;
      tick();
      ccc_valid_i = 1'b0;
   endtask

   task automatic check_state();
      chk("u0_rstact", 64'(rst0), 64'(m_rstact));
      chk("u1_rstact", 64'(rst1), 64'(m_rstact));
      chk("u0_int_en", 64'(int0), 64'(m_int));
      chk("u1_int_en", 64'(int1), 64'(m_int));
      chk("u0_crr_en", 64'(crr0), 64'(m_crr));
      chk("u1_crr_en", 64'(crr1), 64'(m_crr));
      chk("u0_hj_en", 64'(hj0), 64'(m_hj));
      chk("u1_hj_en", 64'(hj1), 64'(m_hj));
      chk("u0_hdr", 64'(hdr0), 64'(m_hdr));
      chk("u1_hdr", 64'(hdr1), 64'(m_hdr));
   endtask

   task automatic model_reset();
      m_rstact = 8'h00;
      m_int = 1'b1;
      m_crr = 1'b1;
      m_hj = 1'b1;
      m_hdr = 1'b0;
   endtask

   task automatic wait_idle(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int k = 0; k < 200; k++) begin
         if (!r0_valid && !r1_valid) return;
         c0 += int'(r0_valid);
         c1 += int'(r1_valid);
         tick();
      end
      chk("idle_timeout", 64'(r0_valid | r1_valid), 64'h0);
   endtask

   task automatic do_get(input logic [7:0] code, input int abort_after,
                         output int c0, output int c1);
      push_expected(code);
      issue(code);
      chk("u0_valid_after_accept", 64'(r0_valid), 64'h1);
      rand_src();
      if (abort_after >= 0) begin
         repeat (abort_after) tick();
         ccc_abort_i = 1'b1;
         tick();
         ccc_abort_i = 1'b0;
         q0.delete();
         q1.delete();
         chk("u0_valid_after_abort", 64'(r0_valid), 64'h0);
         chk("u1_valid_after_abort", 64'(r1_valid), 64'h0);
      end
      wait_idle(c0, c1);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         ccc_valid_i = 1'b1;
         ccc_code_i = 8'h7F;
         tick();
         ccc_valid_i = 1'b0;
         chk("u0_ignored_code", 64'(uns0), 64'h0);
      end
   endtask

   task automatic do_rstact(input logic [7:0] code, input logic [7:0] b,
                            input int gap, input bit ab);
      bit pulse;
      issue(code);
      idle_gap(gap);
      def_valid_i = 1'b1;
      def_byte_i = b;
      ccc_abort_i = ab;
      tick();
      def_valid_i = 1'b0;
      ccc_abort_i = 1'b0;
      pulse = !ab && (b <= 8'h02);
      if (pulse) m_rstact = b;
      chk("u0_rstact_pulse", 64'(rv0), 64'(pulse));
      chk("u1_rstact_pulse", 64'(rv1), 64'(pulse));
      check_state();
      tick();
      chk("u0_rstact_pulse_end", 64'(rv0), 64'h0);
   endtask

   task automatic do_ec(input logic [7:0] code, input logic [7:0] d,
                        input int gap, input bit ab);
      bit en;
      issue(code);
      idle_gap(gap);
      def_valid_i = 1'b1;
      def_byte_i = d;
      ccc_abort_i = ab;
      tick();
      def_valid_i = 1'b0;
      ccc_abort_i = 1'b0;
      en = (code == 8'h00) || (code == 8'h80);
      if (!ab) begin
         if (d[0]) m_int = en;
         if (d[1]) m_crr = en;
         if (d[3]) m_hj = en;
      end
      check_state();
   endtask

   task automatic do_unsup(input logic [7:0] code);
      issue(code);
      chk("u0_unsup_pulse", 64'(uns0), 64'h1);
      chk("u1_unsup_pulse", 64'(uns1), 64'h1);
      chk("u0_unsup_no_resp", 64'(r0_valid), 64'h0);
      tick();
      chk("u0_unsup_pulse_end", 64'(uns0), 64'h0);
      check_state();
   endtask

   task automatic do_hdr();
      issue(8'h20);
      m_hdr = 1'b1;
      check_state();
      issue(8'h8E);
      chk("u0_hdr_ignore_get", 64'(r0_valid), 64'h0);
      chk("u1_hdr_ignore_get", 64'(r1_valid), 64'h0);
      issue(8'h7F);
      chk("u0_hdr_ignore_unsup", 64'(uns0), 64'h0);
      hdr_exit_i = 1'b1;
      tick();
      hdr_exit_i = 1'b0;
      m_hdr = 1'b0;
      check_state();
   endtask

   // Scoreboard: pop on every completed handshake, check hold on stalls.
   always @(negedge clk) begin
      if (rst_ni && !ccc_abort_i && r0_valid) begin
         if (q0.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL u0_unexpected_byte: got %h expected none", r0_data);
         end else if (resp_ready_i) begin
            chk("u0_byte", 64'({r0_last, r0_data}), 64'(q0.pop_front()));
         end else begin
            chk("u0_hold", 64'({r0_last, r0_data}), 64'(q0[0]));
         end
      end
      if (rst_ni && !ccc_abort_i && r1_valid) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL u1_unexpected_byte: got %h expected none", r1_data);
         end else if (resp_ready_i) begin
            chk("u1_byte", 64'({r1_last, r1_data}), 64'(q1.pop_front()));
         end else begin
            chk("u1_hold", 64'({r1_last, r1_data}), 64'(q1[0]));
         end
      end
   end

   initial begin
      resp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         resp_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      int c0, c1;
      rst_ni = 1'b0;
      ccc_valid_i = 1'b0;
      ccc_code_i = 8'h00;
      def_valid_i = 1'b0;
      def_byte_i = 8'h00;
      ccc_abort_i = 1'b0;
      hdr_exit_i = 1'b0;
      rand_src();
      model_reset();
      repeat (3) tick();
      chk("reset_valid", 64'({r0_valid, r1_valid}), 64'h0);
      chk("reset_last", 64'({r0_last, r1_last}), 64'h0);
      chk("reset_data", 64'({r0_data, r1_data}), 64'h0);
      chk("reset_pulses", 64'({rv0, rv1, uns0, uns1}), 64'h0);
      check_state();
      rst_ni = 1'b1;
      tick();

      pid_i = 48'h0123456789AB;
      do_get(8'h8D, -1, c0, c1);
      chk("u0_pid_cycles", 64'(c0), 64'd6);
      chk("u1_pid_cycles", 64'(c1), 64'd3);

      rdy_rand = 1'b1;
      mrl_i = 16'h0100;
      ibi_size_i = 8'h20;
      do_get(8'h8C, -1, c0, c1);
      rdy_rand = 1'b0;
      tick();

      do_rstact(8'h2A, 8'h01, 0, 1'b0);
      do_rstact(8'h9A, 8'h05, 1, 1'b0);
      do_ec(8'h01, 8'h0B, 0, 1'b0);
      do_ec(8'h80, 8'h02, 1, 1'b0);

      status_i = 16'hA55A;
      do_get(8'h90, 1, c0, c1);
      bcr_i = 8'h66;
      do_get(8'h8E, -1, c0, c1);

      do_hdr();
      do_unsup(8'h7F);

      ccc_valid_i = 1'b1;
      ccc_code_i = 8'h7F;
      ccc_abort_i = 1'b1;
      tick();
      ccc_valid_i = 1'b0;
      ccc_abort_i = 1'b0;
      chk("abort_drops_code", 64'({uns0, uns1, r0_valid}), 64'h0);

      rand_src();
      push_expected(8'h8D);
      issue(8'h8D);
      tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      q0.delete();
      q1.delete();
      model_reset();
      chk("midreset_valid", 64'({r0_valid, r1_valid}), 64'h0);
      chk("midreset_last", 64'({r0_last, r1_last}), 64'h0);
      check_state();

      for (int it = 0; it < 150; it++) begin
         logic [7:0] c;
         case ($urandom_range(0, 6))
            0, 1, 2: begin
               rand_src();
               rdy_rand = 1'($urandom_range(0, 1));
               c = 8'h8B + 8'($urandom_range(0, 5));
               do_get(c, ($urandom_range(0, 3) == 0) ?
                      int'($urandom_range(0, 4)) : -1, c0, c1);
               rdy_rand = 1'b0;
            end
            3: do_rstact($urandom_range(0, 1) ? 8'h2A : 8'h9A,
                         8'($urandom_range(0, 5)),
                         int'($urandom_range(0, 2)),
                         ($urandom_range(0, 5) == 0));
            4: begin
               case ($urandom_range(0, 3))
                  0: c = 8'h00;
                  1: c = 8'h80;
                  2: c = 8'h01;
                  default: c = 8'h81;
               endcase
               do_ec(c, 8'($urandom), int'($urandom_range(0, 2)),
                     ($urandom_range(0, 5) == 0));
            end
            5: begin
               c = 8'($urandom);
               while (is_known(c)) c = 8'($urandom);
               do_unsup(c);
            end
            default: begin
               if ($urandom_range(0, 1) == 1) begin
                  do_hdr();
               end else begin
                  ccc_valid_i = 1'b1;
                  ccc_code_i = 8'($urandom);
                  ccc_abort_i = 1'b1;
                  tick();
                  ccc_valid_i = 1'b0;
                  ccc_abort_i = 1'b0;
                  chk("abort_drops_code", 64'({uns0, r0_valid}), 64'h0);
                  check_state();
               end
            end
         endcase
         tick();
      end

      repeat (3) tick();
      chk("u0_queue_empty", 64'(q0.size()), 64'h0);
      chk("u1_queue_empty", 64'(q1.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
